storage_loader: RTL

Boot-time copy engine between the program storage drive and main memory. On a start pulse it streams a block of words out of the storage drive's synchronous read port and writes them, one per clock, into main memory. It also reports the copy progress and an XOR checksum of the copied words. It runs on the same clock that drives the storage read port and the memory write port.

---
 rtl/storage_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/storage_loader.sv
// Boot-time copy engine: streams a block from the storage drive's synchronous
// read port into main memory at one word per clock, with progress and XOR checksum.
module storage_loader #(
   parameter int DW          = 32,
   parameter int SADDR_WIDTH = 14,
   parameter int MADDR_WIDTH = 14
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [SADDR_WIDTH-1:0] src_base,
   input  logic [MADDR_WIDTH-1:0] dst_base,
   input  logic [SADDR_WIDTH:0]   word_count,
   output logic [SADDR_WIDTH-1:0] storage_address,
   input  logic [DW-1:0]          storage_data,
   output logic [MADDR_WIDTH-1:0] mem_address,
   output logic [DW-1:0]          mem_data,
   output logic                   mem_write_enable,
   output logic                   busy,
   output logic                   done,
   output logic [SADDR_WIDTH:0]   words_copied,
   output logic [DW-1:0]          checksum
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

   localparam logic [SADDR_WIDTH:0] MAX_N = {1'b1, {SADDR_WIDTH{1'b0}}};
   localparam logic [SADDR_WIDTH:0] ONE   = (SADDR_WIDTH+1)'(1);

   state_t                 state_q, state_d;
   logic [SADDR_WIDTH-1:0] src_q, src_d;
   logic [MADDR_WIDTH-1:0] dst_q, dst_d;
   logic [SADDR_WIDTH:0]   n_q, n_d;
   logic [SADDR_WIDTH:0]   idx_q, idx_d;
   logic [SADDR_WIDTH-1:0] sa_q, sa_d;
   logic [MADDR_WIDTH-1:0] ma_q, ma_d;
   logic [DW-1:0]          md_q, md_d;
   logic                   we_q, we_d;
   logic [SADDR_WIDTH:0]   wc_q, wc_d;
   logic [DW-1:0]          cks_q, cks_d;
   logic                   rd0_q, rd0_d;
   logic                   rd1_q, rd1_d;
   logic [SADDR_WIDTH:0]   n_clamp;

   assign n_clamp = (word_count > MAX_N) ? MAX_N : word_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         n_q     <= '0;
         idx_q   <= '0;
         sa_q    <= '0;
         ma_q    <= '0;
         md_q    <= '0;
         we_q    <= 1'b0;
         wc_q    <= '0;
         cks_q   <= '0;
         rd0_q   <= 1'b0;
         rd1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         sa_q    <= sa_d;
         ma_q    <= ma_d;
         md_q    <= md_d;
         we_q    <= we_d;
         wc_q    <= wc_d;
         cks_q   <= cks_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      n_d     = n_q;
      idx_d   = idx_q;
      sa_d    = sa_q;
      ma_d    = ma_q;
      md_d    = md_q;
      we_d    = 1'b0;
      wc_d    = wc_q;
      cks_d   = cks_q;
      // rd0: address issued at this edge; rd1: storage captured it; write follows
      rd0_d   = 1'b0;
      rd1_d   = rd0_q;

      if ((state_q == STREAM || state_q == DRAIN) && rd1_q) begin
         md_d  = storage_data;
         ma_d  = dst_q + MADDR_WIDTH'(wc_q);
         we_d  = 1'b1;
         wc_d  = wc_q + ONE;
         cks_d = cks_q ^ storage_data;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               src_d   = src_base;
               dst_d   = dst_base;
               n_d     = n_clamp;
               wc_d    = '0;
               cks_d   = '0;
               sa_d    = src_base;
               idx_d   = ONE;
               rd0_d   = (n_clamp != '0);
               // An empty copy still spends one cycle in DRAIN (busy masked) so
               // done lands one cycle after the start edge.
               state_d = (n_clamp != '0) ? STREAM : DRAIN;
            end
         end
         STREAM: begin
            if (idx_q < n_q) begin
               sa_d  = src_q + idx_q[SADDR_WIDTH-1:0];
               idx_d = idx_q + ONE;
               rd0_d = 1'b1;
            end
            if ((idx_q + ONE) >= n_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (wc_q == n_q) begin
               we_d    = 1'b0;
               state_d = FINISH;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign storage_address  = sa_q;
   assign mem_address      = ma_q;
   assign mem_data         = md_q;
   assign mem_write_enable = we_q;
   assign words_copied     = wc_q;
   assign checksum         = cks_q;
   assign busy             = (state_q == STREAM || state_q == DRAIN) && (n_q != '0);
   assign done             = (state_q == FINISH);

endmodule
